// File: rtl/tree_share_arb.sv
// Round-robin arbiter feeding one shared pipelined adder tree.
// Tracks {valid, id} alongside the tree so each result is tagged with its owner.
module tree_share_arb #(
    parameter int unsigned REQ_NUM     = 4,
    parameter int unsigned TREE_STAGES = 7,
    parameter int unsigned ID_WIDTH    = $clog2(REQ_NUM),
    parameter int unsigned CNT_WIDTH   = $clog2(TREE_STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 hold,
    input  logic [REQ_NUM-1:0]   req_valid,
    output logic [REQ_NUM-1:0]   req_ready,
    output logic [ID_WIDTH-1:0]  mux_sel,
    output logic                 mux_valid,
    output logic                 rsp_valid,
    output logic [ID_WIDTH-1:0]  rsp_id,
    output logic [CNT_WIDTH-1:0] inflight,
    output logic                 idle
);

    logic [ID_WIDTH-1:0]    ptr;
    logic                   grant;
    logic [ID_WIDTH-1:0]    grant_idx;
    logic [TREE_STAGES-1:0] pipe_valid;
    logic [ID_WIDTH-1:0]    pipe_id [TREE_STAGES];

    // Index (base + off) wrapped modulo REQ_NUM.
    function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                     input int unsigned off);
        return ID_WIDTH'((32'(base) + off) % REQ_NUM);
    endfunction

    // Round-robin search from ptr; reset forces the grant path quiet.
    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        if (reset_n && !hold) begin
            for (int unsigned i = 0; i < REQ_NUM; i++) begin
                if (!grant && req_valid[wrap_add(ptr, i)]) begin
                    grant     = 1'b1;
                    grant_idx = wrap_add(ptr, i);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[grant_idx] = 1'b1;
        end
        mux_valid = grant;
        mux_sel   = grant_idx;
        idle      = (inflight == '0) && !grant;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= wrap_add(grant_idx, 1);
        end
    end

    // Tag pipeline: same depth as the tree, free-running, no stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid <= '0;
            for (int unsigned s = 0; s < TREE_STAGES; s++) begin
                pipe_id[s] <= '0;
            end
        end else begin
            pipe_valid[0] <= grant;
            pipe_id[0]    <= grant_idx;
            for (int unsigned s = 1; s < TREE_STAGES; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                pipe_id[s]    <= pipe_id[s-1];
            end
        end
    end

    assign rsp_valid = pipe_valid[TREE_STAGES-1];
    assign rsp_id    = pipe_id[TREE_STAGES-1];

    // A simultaneous grant and retire leaves the count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= '0;
        end else if (grant && !rsp_valid) begin
            inflight <= inflight + CNT_WIDTH'(1);
        end else if (!grant && rsp_valid) begin
            inflight <= inflight - CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_tree_share_arb.sv
// Randomized and directed check of tree_share_arb against a grant-history model.
module tb_tree_share_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned S  = 7;
    localparam int unsigned IW = 2;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          hold;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [IW-1:0] mux_sel;
    logic          mux_valid;
    logic          rsp_valid;
    logic [IW-1:0] rsp_id;
    logic [CW-1:0] inflight;
    logic          idle;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int ptr_m = 0;
    int q_cyc[$];
    int q_id[$];

    tree_share_arb #(.REQ_NUM(N), .TREE_STAGES(S)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .hold      (hold),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .mux_sel   (mux_sel),
        .mux_valid (mux_valid),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .inflight  (inflight),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, obs, exp);
        end
    endtask

    // First asserted requester at or after p, wrapping; -1 when nothing is granted.
    function automatic int exp_grant(input logic [N-1:0] rv, input logic h,
                                     input logic rn, input int p);
        if (!rn || h) return -1;
        for (int i = 0; i < N; i++) begin
            if (rv[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    // One clock: drive inputs, check outputs against the model, advance past the edge.
    task automatic step(input logic [N-1:0] rv, input logic h, input logic rn, output int g);
        int rsp;
        int cnt;
        req_valid = rv;
        hold      = h;
        reset_n   = rn;
        if (!rn) begin
            q_cyc.delete();
            q_id.delete();
            ptr_m = 0;
        end
        g   = exp_grant(rv, h, rn, ptr_m);
        rsp = -1;
        cnt = 0;
        foreach (q_cyc[k]) begin
            if (q_cyc[k] + S == cyc) rsp = q_id[k];
            if (q_cyc[k] < cyc && cyc <= q_cyc[k] + S) cnt++;
        end
        #2;
        chk("mux_valid", 32'(mux_valid), (g >= 0) ? 1 : 0);
        chk("mux_sel",   32'(mux_sel),   (g >= 0) ? g : 0);
        chk("req_ready", 32'(req_ready), (g >= 0) ? (1 << g) : 0);
        chk("rsp_valid", 32'(rsp_valid), (rsp >= 0) ? 1 : 0);
        if (rsp >= 0) chk("rsp_id", 32'(rsp_id), rsp);
        chk("inflight",  32'(inflight),  cnt);
        chk("idle",      32'(idle),      (cnt == 0 && g < 0) ? 1 : 0);
        @(posedge clk);
        #1;
        if (g >= 0) begin
            q_cyc.push_back(cyc);
            q_id.push_back(g);
            ptr_m = (g + 1) % N;
        end
        while (q_cyc.size() > 0 && q_cyc[0] + S <= cyc) begin
            void'(q_cyc.pop_front());
            void'(q_id.pop_front());
        end
        cyc++;
    endtask

    task automatic run(input logic [N-1:0] rv, input logic h, input int n);
        int g;
        for (int i = 0; i < n; i++) step(rv, h, 1'b1, g);
    endtask

    task automatic do_reset(input int n);
        int g;
        for (int i = 0; i < n; i++) step(4'b1111, 1'b0, 1'b0, g);
    endtask

    initial begin
        int g;
        logic [N-1:0] pend;
        logic rn;
        logic h;
        reset_n   = 1'b0;
        hold      = 1'b0;
        req_valid = '0;
        #1;

        // Single request after a quiet stretch
        do_reset(3);
        run(4'b0000, 1'b0, 7);
        run(4'b0100, 1'b0, 1);
        run(4'b0000, 1'b0, 10);

        // Fairness from reset, then saturation with one continuous requester
        do_reset(2);
        run(4'b1111, 1'b0, 8);
        run(4'b0001, 1'b0, 20);
        chk("sat_inflight", 32'(inflight), S);

        // Hold mid-stream
        do_reset(2);
        run(4'b1111, 1'b0, 3);
        run(4'b1111, 1'b1, 4);
        run(4'b1111, 1'b0, 2);
        run(4'b0000, 1'b0, 10);

        // Reset mid-flight discards pending responses
        do_reset(2);
        run(4'b1111, 1'b0, 3);
        do_reset(2);
        run(4'b0000, 1'b0, 10);
        run(4'b1111, 1'b0, 1);
        run(4'b0000, 1'b0, 8);

        // Sparse wrap from ptr = 3
        do_reset(2);
        run(4'b0100, 1'b0, 1);
        run(4'b0001, 1'b0, 1);
        run(4'b0010, 1'b0, 1);
        run(4'b0000, 1'b0, 9);

        // Random traffic with requesters that hold until accepted
        pend = '0;
        for (int i = 0; i < 3000; i++) begin
            rn   = ($urandom_range(0, 199) != 0);
            h    = ($urandom_range(0, 4) == 0);
            pend = pend | (N'($urandom) & N'($urandom));
            step(pend, h, rn, g);
            if (!rn) pend = '0;
            else if (g >= 0) pend[g] = 1'b0;
        end
        run(4'b0000, 1'b0, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
